// File: rtl/ss_gen_pkg.sv
// Shared constants for the polar stochastic generator: maximal-length LFSR taps,
// default seed, channel count and a rotate helper used to derive per-channel values.
package ss_gen_pkg;

  localparam int unsigned SS_NUM_CH       = 32'd4;
  localparam logic [15:0] SS_DEFAULT_SEED = 16'h00A5;

  // Fibonacci feedback masks (bit i set = state bit i feeds the XOR); all maximal-length.
  function automatic logic [15:0] lfsr_taps(input int unsigned n);
    logic [15:0] t;
    case (n)
      32'd4:   t = 16'h000C;
      32'd5:   t = 16'h0014;
      32'd6:   t = 16'h0030;
      32'd7:   t = 16'h0060;
      32'd8:   t = 16'h00B8;
      32'd9:   t = 16'h0110;
      32'd10:  t = 16'h0240;
      32'd11:  t = 16'h0500;
      32'd12:  t = 16'h0829;
      32'd13:  t = 16'h100D;
      32'd14:  t = 16'h2015;
      32'd15:  t = 16'h6000;
      32'd16:  t = 16'hD008;
      default: t = 16'h00B8;
    endcase
    return t;
  endfunction

  // Rotate the low n bits of v left by s positions (s taken mod n).
  function automatic logic [15:0] rotl_n(input logic [15:0] v, input int unsigned n,
                                         input int unsigned s);
    logic [15:0] m;
    logic [15:0] r;
    m = 16'hFFFF >> (32'd16 - n);
    r = v & m;
    for (int unsigned i = 0; i < 32'd16; i++) begin
      if (i < (s % n)) begin
        r = ((r << 1) | (r >> (n - 32'd1))) & m;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ss_lfsr.sv
// Fibonacci maximal-length LFSR; advances only while EN is high, reloads SEED on reset.
module ss_lfsr
  import ss_gen_pkg::*;
#(
  parameter int           N    = 8,
  parameter logic [N-1:0] SEED = N'(SS_DEFAULT_SEED)
) (
  input  logic         CLK,
  input  logic         INIT_n,
  input  logic         EN,
  output logic [N-1:0] STATE
);

  localparam logic [N-1:0] TAPS = N'(lfsr_taps(N));

  logic [N-1:0] state_q;
  logic [N-1:0] state_d;

  // Next state: shift left, feedback XOR into bit 0; zero is unreachable from a nonzero seed.
  always_comb begin
    state_d = state_q;
    if (EN) begin
      state_d = {state_q[N-2:0], ^(state_q & TAPS)};
    end else begin
      state_d = state_q;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge INIT_n) begin
    if (!INIT_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign STATE = state_q;

endmodule

// File: rtl/ss_polar_gen_4ch.sv
// Four-channel polar stochastic bitstream generator with double-buffered magnitudes/signs.
// Build option SS_GEN_DECORR_EN: one LFSR per channel instead of one shared rotated LFSR.
module ss_polar_gen_4ch
  import ss_gen_pkg::*;
#(
  parameter int           N    = 8,
  parameter logic [N-1:0] SEED = N'(SS_DEFAULT_SEED)
) (
  input  logic         CLK,
  input  logic         INIT_n,
  input  logic         EN,
  input  logic         LOAD,
  input  logic [1:0]   LOAD_IDX,
  input  logic [N-1:0] LOAD_VAL,
  input  logic         LOAD_SIGN,
  output logic [3:0]   OUT_SS,
  output logic [3:0]   SIGN_OUT,
  output logic         FRAME_DONE
);

  localparam logic [N-1:0] FC_MAX = {{(N-1){1'b1}}, 1'b0};
  localparam logic [N-1:0] FC_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [SS_NUM_CH-1:0][N-1:0] shadow_mag_q, shadow_mag_d;
  logic [SS_NUM_CH-1:0]        shadow_sign_q, shadow_sign_d;
  logic [SS_NUM_CH-1:0][N-1:0] active_mag_q, active_mag_d;
  logic [SS_NUM_CH-1:0]        active_sign_q, active_sign_d;
  logic [N-1:0]                fc_q, fc_d;
  logic [3:0]                  out_ss_q, out_ss_d;
  logic [3:0]                  sign_out_q, sign_out_d;
  logic                        frame_done_q, frame_done_d;
  logic                        commit_s;
  logic [SS_NUM_CH-1:0][N-1:0] r_s;

`ifdef SS_GEN_DECORR_EN
  for (genvar k = 0; k < SS_NUM_CH; k++) begin : g_lfsr
    logic [N-1:0] lfsr_state_s;
    ss_lfsr #(
      .N    (N),
      .SEED (N'(rotl_n(16'(SEED), N, k)))
    ) u_lfsr (
      .CLK    (CLK),
      .INIT_n (INIT_n),
      .EN     (EN),
      .STATE  (lfsr_state_s)
    );
    assign r_s[k] = lfsr_state_s;
  end
`else
  logic [N-1:0] lfsr_state_s;
  ss_lfsr #(
    .N    (N),
    .SEED (SEED)
  ) u_lfsr (
    .CLK    (CLK),
    .INIT_n (INIT_n),
    .EN     (EN),
    .STATE  (lfsr_state_s)
  );
  // Rotation is a bijection, so each channel still sees every nonzero value once per frame.
  for (genvar k = 0; k < SS_NUM_CH; k++) begin : g_rot
    assign r_s[k] = N'(rotl_n(16'(lfsr_state_s), N, 2 * k));
  end
`endif

  // Shadow write, frame commit (with write-through of a same-cycle load) and frame counter.
  always_comb begin
    shadow_mag_d  = shadow_mag_q;
    shadow_sign_d = shadow_sign_q;
    if (LOAD) begin
      shadow_mag_d[LOAD_IDX]  = LOAD_VAL;
      shadow_sign_d[LOAD_IDX] = LOAD_SIGN;
    end else begin
      shadow_mag_d  = shadow_mag_q;
      shadow_sign_d = shadow_sign_q;
    end

    commit_s = EN && (fc_q == FC_MAX);

    if (commit_s) begin
      active_mag_d  = shadow_mag_d;
      active_sign_d = shadow_sign_d;
      fc_d          = {N{1'b0}};
    end else if (EN) begin
      active_mag_d  = active_mag_q;
      active_sign_d = active_sign_q;
      fc_d          = fc_q + FC_ONE;
    end else begin
      active_mag_d  = active_mag_q;
      active_sign_d = active_sign_q;
      fc_d          = fc_q;
    end
  end

  // Comparators and output next-state; outputs idle low (sign holds) while EN is low.
  always_comb begin
    out_ss_d     = 4'b0000;
    sign_out_d   = sign_out_q;
    frame_done_d = commit_s;
    for (int k = 0; k < SS_NUM_CH; k++) begin
      out_ss_d[k] = EN && (r_s[k] <= active_mag_q[k]);
    end
    if (EN) begin
      sign_out_d = active_sign_q;
    end else begin
      sign_out_d = sign_out_q;
    end
  end

  // Value banks, frame counter and output registers.
  always_ff @(posedge CLK or negedge INIT_n) begin
    if (!INIT_n) begin
      shadow_mag_q  <= {(SS_NUM_CH*N){1'b0}};
      shadow_sign_q <= {SS_NUM_CH{1'b0}};
      active_mag_q  <= {(SS_NUM_CH*N){1'b0}};
      active_sign_q <= {SS_NUM_CH{1'b0}};
      fc_q          <= {N{1'b0}};
      out_ss_q      <= 4'b0000;
      sign_out_q    <= 4'b0000;
      frame_done_q  <= 1'b0;
    end else begin
      shadow_mag_q  <= shadow_mag_d;
      shadow_sign_q <= shadow_sign_d;
      active_mag_q  <= active_mag_d;
      active_sign_q <= active_sign_d;
      fc_q          <= fc_d;
      out_ss_q      <= out_ss_d;
      sign_out_q    <= sign_out_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign OUT_SS     = out_ss_q;
  assign SIGN_OUT   = sign_out_q;
  assign FRAME_DONE = frame_done_q;

endmodule
